// File: rtl/sigma_delta_adc.sv
// sigma_delta_adc -- stereo first-order sigma-delta ADC front end.
//
// Each comparator bitstream is synchronised, registered as the feedback bit
// (which is also the filter input, +1/-1), then decimated by 2^DECIM_LOG2
// with a third-order CIC filter and emitted as signed PCM pairs.
//
// Parameters:
//   DECIM_LOG2 : log2 of decimation ratio R, legal 5..10
//   OW         : PCM width, OW <= 3*DECIM_LOG2+1
// Ports:
//   clk, reset            : single clock, synchronous active-high reset
//   ce                    : modulator sample enable (bitstream rate)
//   bs_left, bs_right     : asynchronous comparator outputs
//   fb_left, fb_right     : feedback bits back to the RC networks
//   pcm_left, pcm_right   : signed PCM samples, held between strobes
//   pcm_valid             : one-cycle strobe for a new sample pair

// Per-channel datapath: synchroniser, sample register, integrators,
// decimation register, comb pipeline, scaling/saturation, output register.
module sdadc_lane #(
    parameter int W  = 20,
    parameter int OW = 16,
    parameter int SH = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    input  logic          cap,       // capture i3 into the decimation register
    input  logic [3:0]    stage_en,  // comb1, comb2, comb3, output register
    input  logic          bs,
    output logic          fb,
    output logic [OW-1:0] pcm
);
    logic [1:0]          sync;
    logic signed [W-1:0] x;
    logic signed [W-1:0] i1, i2, i3, d;
    logic signed [W-1:0] z1, z2, z3;
    logic signed [W-1:0] c1, c2, c3;
    logic signed [W-1:0] y_sh;
    logic                ovf;
    logic [OW-1:0]       sat_val;

    assign x = fb ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};

    // Everything above bit OW-2 of the shifted value must be pure sign
    // extension; otherwise clamp toward the sign.
    always_comb begin
        y_sh    = c3 >>> SH;
        ovf     = !((&y_sh[W-1:OW-1]) || !(|y_sh[W-1:OW-1]));
        sat_val = y_sh[OW-1:0];
        if (ovf)
            sat_val = {y_sh[W-1], {(OW-1){~y_sh[W-1]}}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
            fb   <= 1'b0;
            i1   <= '0;
            i2   <= '0;
            i3   <= '0;
            d    <= '0;
            z1   <= '0;
            z2   <= '0;
            z3   <= '0;
            c1   <= '0;
            c2   <= '0;
            c3   <= '0;
            pcm  <= '0;
        end else begin
            sync <= {sync[0], bs};
            // Integrators wrap modulo 2^W; the comb differences undo it.
            if (ce) begin
                fb <= sync[1];
                i1 <= i1 + x;
                i2 <= i2 + i1;
                i3 <= i3 + i2;
            end
            if (cap)
                d <= i3;
            // Comb delays advance only when a new value enters the stage.
            if (stage_en[0]) begin
                c1 <= d - z1;
                z1 <= d;
            end
            if (stage_en[1]) begin
                c2 <= c1 - z2;
                z2 <= c1;
            end
            if (stage_en[2]) begin
                c3 <= c2 - z3;
                z3 <= c2;
            end
            if (stage_en[3])
                pcm <= sat_val;
        end
    end
endmodule

module sigma_delta_adc #(
    parameter int DECIM_LOG2 = 6,
    parameter int OW         = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    input  logic          bs_left,
    input  logic          bs_right,
    output logic          fb_left,
    output logic          fb_right,
    output logic [OW-1:0] pcm_left,
    output logic [OW-1:0] pcm_right,
    output logic          pcm_valid
);
    localparam int NUM_LANES = 2;
    localparam int W         = 3*DECIM_LOG2 + 2;
    localparam int SH        = 3*DECIM_LOG2 + 1 - OW;
    localparam int STAGES    = 4;

    logic [DECIM_LOG2-1:0]          dec_cnt;
    logic                           cap;
    logic [STAGES:0]                vld_pipe;
    logic [NUM_LANES-1:0]           bs_vec;
    logic [NUM_LANES-1:0]           fb_vec;
    logic [NUM_LANES-1:0][OW-1:0]   pcm_vec;

    assign cap    = ce & (&dec_cnt);
    assign bs_vec = {bs_right, bs_left};

    // vld_pipe[0]: decimation register loaded; [1..3]: comb stages done;
    // [STAGES]: output register loaded. Runs every clock, independent of ce.
    always_ff @(posedge clk) begin
        if (reset) begin
            dec_cnt  <= '0;
            vld_pipe <= '0;
        end else begin
            if (ce)
                dec_cnt <= dec_cnt + 1'b1;
            vld_pipe <= {vld_pipe[STAGES-1:0], cap};
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        sdadc_lane #(.W(W), .OW(OW), .SH(SH)) u_lane (
            .clk      (clk),
            .reset    (reset),
            .ce       (ce),
            .cap      (cap),
            .stage_en (vld_pipe[STAGES-1:0]),
            .bs       (bs_vec[g]),
            .fb       (fb_vec[g]),
            .pcm      (pcm_vec[g])
        );
    end

    assign fb_left   = fb_vec[0];
    assign fb_right  = fb_vec[1];
    assign pcm_left  = pcm_vec[0];
    assign pcm_right = pcm_vec[1];
    assign pcm_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_sigma_delta_adc.sv
module tb_sigma_delta_adc;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic        bs_left = 1'b0;
    logic        bs_right = 1'b0;
    logic        fb_left, fb_right;
    logic [15:0] pcm_left, pcm_right;
    logic        pcm_valid;

    sigma_delta_adc dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .bs_left   (bs_left),
        .bs_right  (bs_right),
        .fb_left   (fb_left),
        .fb_right  (fb_right),
        .pcm_left  (pcm_left),
        .pcm_right (pcm_right),
        .pcm_valid (pcm_valid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0, ph = 0, nvalid = 0, first_vcyc = 0, prev_vcyc = 0, period = 0;
    int dbl = 0, hold_viol = 0, fb_viol = 0;
    int ce_div = 1;
    bit manual = 1'b0;
    logic [3:0]  pat_l = 4'b0000, pat_r = 4'b0000;
    logic [15:0] sl [0:15];
    logic [15:0] sr [0:15];
    logic        prev_valid = 1'b0, prev_fbl = 1'b0, prev_fbr = 1'b0;
    logic [15:0] prev_l = '0, prev_r = '0;

    // One clock: sample #1 after the edge, log strobes, then drive next inputs.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (ce) ph++;
        if (!reset) begin
            if (!pcm_valid && (pcm_left !== prev_l || pcm_right !== prev_r)) hold_viol++;
            if (!ce && (fb_left !== prev_fbl || fb_right !== prev_fbr)) fb_viol++;
            if (pcm_valid && prev_valid) dbl++;
            if (pcm_valid) begin
                if (nvalid == 0) first_vcyc = cyc;
                else period = cyc - prev_vcyc;
                prev_vcyc = cyc;
                if (nvalid < 16) begin
                    sl[nvalid] = pcm_left;
                    sr[nvalid] = pcm_right;
                end
                nvalid++;
            end
        end
        prev_valid = pcm_valid;
        prev_l     = pcm_left;
        prev_r     = pcm_right;
        prev_fbl   = fb_left;
        prev_fbr   = fb_right;
        ce = (ce_div == 1) || (cyc % 2 == 0);
        if (!manual) begin
            bs_left  = pat_l[ph[1:0]];
            bs_right = pat_r[ph[1:0]];
        end
    endtask

    task automatic restart();
        cyc = 0; ph = 0; nvalid = 0; period = 0; first_vcyc = 0;
        ce = 1'b1;
        if (!manual) begin
            bs_left  = pat_l[0];
            bs_right = pat_r[0];
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        restart();
    endtask

    task automatic test_reset();
        reset = 1'b1; ce = 1'b0;
        step();
        step();
        tests++; if (pcm_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", pcm_valid); end
        tests++; if (pcm_left !== 16'h0) begin fails++; $display("FAIL rst_pcm_left: got %h want 0000", pcm_left); end
        tests++; if (pcm_right !== 16'h0) begin fails++; $display("FAIL rst_pcm_right: got %h want 0000", pcm_right); end
        tests++; if (fb_left !== 1'b0) begin fails++; $display("FAIL rst_fb_left: got %b want 0", fb_left); end
        tests++; if (fb_right !== 1'b0) begin fails++; $display("FAIL rst_fb_right: got %b want 0", fb_right); end
    endtask

    task automatic test_full_scale();
        manual = 1'b0; ce_div = 1; pat_l = 4'b1111; pat_r = 4'b0000;
        do_reset();
        while (nvalid < 8 && cyc < 1000) step();
        tests++; if (nvalid < 8) begin fails++; $display("FAIL fs_timeout: got %0d strobes want 8", nvalid); end
        tests++; if (first_vcyc != 68) begin fails++; $display("FAIL fs_first_valid: got %0d want 68", first_vcyc); end
        tests++; if (period != 64) begin fails++; $display("FAIL fs_period: got %0d want 64", period); end
        tests++; if (sl[3] !== 16'h7FFF) begin fails++; $display("FAIL fs_left3: got %h want 7fff", sl[3]); end
        tests++; if (sl[7] !== 16'h7FFF) begin fails++; $display("FAIL fs_left7: got %h want 7fff", sl[7]); end
        tests++; if (sr[3] !== 16'h8000) begin fails++; $display("FAIL fs_right3: got %h want 8000", sr[3]); end
        tests++; if (sr[7] !== 16'h8000) begin fails++; $display("FAIL fs_right7: got %h want 8000", sr[7]); end
    endtask

    task automatic test_midscale();
        manual = 1'b0; ce_div = 1; pat_l = 4'b0101; pat_r = 4'b0111;
        do_reset();
        while (nvalid < 5 && cyc < 800) step();
        tests++; if (nvalid < 5) begin fails++; $display("FAIL mid_timeout: got %0d strobes want 5", nvalid); end
        tests++; if (sl[3] !== 16'h0000) begin fails++; $display("FAIL mid_left3: got %h want 0000", sl[3]); end
        tests++; if (sl[4] !== 16'h0000) begin fails++; $display("FAIL mid_left4: got %h want 0000", sl[4]); end
        tests++; if (sr[4] !== 16'h4000) begin fails++; $display("FAIL mid_right4: got %h want 4000", sr[4]); end
    endtask

    task automatic test_duty75();
        manual = 1'b0; ce_div = 1; pat_l = 4'b0111; pat_r = 4'b0101;
        do_reset();
        while (nvalid < 5 && cyc < 800) step();
        tests++; if (nvalid < 5) begin fails++; $display("FAIL d75_timeout: got %0d strobes want 5", nvalid); end
        tests++; if (sl[3] !== 16'h4000) begin fails++; $display("FAIL d75_left3: got %h want 4000", sl[3]); end
        tests++; if (sl[4] !== 16'h4000) begin fails++; $display("FAIL d75_left4: got %h want 4000", sl[4]); end
        tests++; if (sr[4] !== 16'h0000) begin fails++; $display("FAIL d75_right4: got %h want 0000", sr[4]); end
    endtask

    task automatic test_ce_gating();
        manual = 1'b0; ce_div = 2; pat_l = 4'b0111; pat_r = 4'b1111;
        do_reset();
        fb_viol = 0;
        while (nvalid < 6 && cyc < 1500) step();
        tests++; if (nvalid < 6) begin fails++; $display("FAIL ce_timeout: got %0d strobes want 6", nvalid); end
        tests++; if (first_vcyc != 131) begin fails++; $display("FAIL ce_first_valid: got %0d want 131", first_vcyc); end
        tests++; if (period != 128) begin fails++; $display("FAIL ce_period: got %0d want 128", period); end
        tests++; if (sl[4] !== 16'h4000) begin fails++; $display("FAIL ce_left4: got %h want 4000", sl[4]); end
        tests++; if (sr[4] !== 16'h7FFF) begin fails++; $display("FAIL ce_right4: got %h want 7fff", sr[4]); end
        tests++; if (fb_viol != 0) begin fails++; $display("FAIL ce_fb_gating: got %0d changes off-ce want 0", fb_viol); end
        ce_div = 1;
    endtask

    task automatic test_reset_mid();
        manual = 1'b0; ce_div = 1; pat_l = 4'b1111; pat_r = 4'b1111;
        do_reset();
        // Second capture lands on clock 128; reset at 130 hits the comb pipeline.
        while (cyc < 129) step();
        reset = 1'b1;
        step();
        tests++; if (pcm_valid !== 1'b0) begin fails++; $display("FAIL rm_valid: got %b want 0", pcm_valid); end
        tests++; if (pcm_left !== 16'h0) begin fails++; $display("FAIL rm_pcm_left: got %h want 0000", pcm_left); end
        tests++; if (pcm_right !== 16'h0) begin fails++; $display("FAIL rm_pcm_right: got %h want 0000", pcm_right); end
        tests++; if (fb_left !== 1'b0) begin fails++; $display("FAIL rm_fb_left: got %b want 0", fb_left); end
        reset = 1'b0;
        restart();
        while (nvalid < 4 && cyc < 600) step();
        tests++; if (nvalid < 4) begin fails++; $display("FAIL rm_timeout: got %0d strobes want 4", nvalid); end
        tests++; if (first_vcyc != 68) begin fails++; $display("FAIL rm_first_valid: got %0d want 68", first_vcyc); end
        tests++; if (sl[3] !== 16'h7FFF) begin fails++; $display("FAIL rm_left3: got %h want 7fff", sl[3]); end
        tests++; if (sr[3] !== 16'h7FFF) begin fails++; $display("FAIL rm_right3: got %h want 7fff", sr[3]); end
    endtask

    task automatic test_fb_latency();
        manual = 1'b1; ce_div = 1;
        bs_left = 1'b0; bs_right = 1'b0;
        do_reset();
        repeat (4) step();
        bs_left = 1'b1;
        step();
        tests++; if (fb_left !== 1'b0) begin fails++; $display("FAIL lat_rise1: got %b want 0", fb_left); end
        step();
        tests++; if (fb_left !== 1'b0) begin fails++; $display("FAIL lat_rise2: got %b want 0", fb_left); end
        step();
        tests++; if (fb_left !== 1'b1) begin fails++; $display("FAIL lat_rise3: got %b want 1", fb_left); end
        tests++; if (fb_right !== 1'b0) begin fails++; $display("FAIL lat_right: got %b want 0", fb_right); end
        bs_left = 1'b0;
        step();
        step();
        tests++; if (fb_left !== 1'b1) begin fails++; $display("FAIL lat_fall2: got %b want 1", fb_left); end
        step();
        tests++; if (fb_left !== 1'b0) begin fails++; $display("FAIL lat_fall3: got %b want 0", fb_left); end
        manual = 1'b0;
    endtask

    task automatic test_output_hold();
        tests++; if (hold_viol != 0) begin fails++; $display("FAIL hold: got %0d changes without strobe want 0", hold_viol); end
        tests++; if (dbl != 0) begin fails++; $display("FAIL pulse_width: got %0d multi-cycle strobes want 0", dbl); end
    endtask

    initial begin
        test_reset();
        test_full_scale();
        test_midscale();
        test_duty75();
        test_ce_gating();
        test_reset_mid();
        test_fb_latency();
        test_output_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sigma_delta_adc.md
# sigma_delta_adc

Stereo first-order sigma-delta ADC front end with CIC3 decimation, the receive-side counterpart of the audio bitstream DAC. It samples two external comparator bitstreams (RC-integrated feedback loop closed through `fb_left`/`fb_right`). It then decimates each stream by 2^DECIM_LOG2 with a third-order CIC filter and emits signed PCM sample pairs with a one-cycle valid strobe. It sits between the board-level comparator pins and the audio capture path, for example a cassette or voice input.

## Interface
- `DECIM_LOG2`, default 6: log2 of the decimation ratio R. Legal range 5..10.
- `OW`, default 16: PCM output width. Must satisfy OW <= 3*DECIM_LOG2+1.
- `clk` input, 1 bit: single clock; all logic is on its rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `ce` input, 1 bit: modulator sample enable. The bitstream is sampled and the filter advances only when `ce`=1.
- `bs_left` input, 1 bit: left comparator output (asynchronous).
- `bs_right` input, 1 bit: right comparator output (asynchronous).
- `fb_left` output, 1 bit: left feedback bit driven back to the RC network.
- `fb_right` output, 1 bit: right feedback bit driven back to the RC network.
- `pcm_left` output, OW bits: signed left sample.
- `pcm_right` output, OW bits: signed right sample.
- `pcm_valid` output, 1 bit: one-cycle pulse marking a new `pcm_left`/`pcm_right` pair.

## Operation
- **Input synchroniser.** Each bitstream passes through a 2-flop synchroniser that runs every clock.
- **Sample register.** On `ce`, `fb_x` <= synchroniser output. `fb_x` is both the feedback output and the filter input.
- **Input mapping.** `fb_x`=1 maps to +1 and `fb_x`=0 maps to -1, in signed width W = 3*DECIM_LOG2+2.
- **Integrators.** Three cascaded integrators per channel, each W bits. On `ce`: i1 <= i1 + x, i2 <= i2 + i1, i3 <= i3 + i2, using registered values. Wrap-around is modulo 2^W. Overflow is intentional and must not be saturated.
- **Decimation counter.** DECIM_LOG2 bits, shared by both channels, increments on `ce` and wraps from 2^DECIM_LOG2-1 to 0.
- **Decimation capture.** On the `ce` cycle where the counter equals 2^DECIM_LOG2-1, the current registered i3 of each channel is copied into the decimation register d.
- **Comb pipeline.** Three registered comb stages, each W bits, modulo 2^W. Each stage computes c_k = in_k - previous in_k, where the delay element updates only when a new value enters that stage. Stages fire on consecutive clocks after the capture, regardless of `ce`.
- **Scaling.** The comb result y lies in [-2^(3D), +2^(3D)], where D = DECIM_LOG2. y is arithmetically shifted right by 3D+1-OW.
- **Saturation.** The shifted value is saturated to the range [-2^(OW-1), 2^(OW-1)-1]. In practice only the positive full-scale value +2^(OW-1) saturates, to 0x7FF..F.
- **Output register.** The final stage registers `pcm_left`/`pcm_right` and pulses `pcm_valid`. Both channels always update together.
- **Reset.** Clears the synchronisers, `fb_x`, all integrators, the decimation counter, d, the comb delays and comb registers, `pcm_x` and `pcm_valid` to 0.
- **Settling.** The first 3 PCM outputs after reset are settling transients. They are still emitted with `pcm_valid`.
- **Reset mid-operation.** Any in-flight comb result is discarded, and no `pcm_valid` pulse is produced in the cycle following reset.

## Timing
- **Pin to feedback.** `bs_x` to `fb_x`: 2 clocks of synchroniser, plus the next `ce` edge.
- **Capture to valid.** The capture edge is counted as cycle 0. Comb stages register at cycles 1, 2 and 3. The output register and `pcm_valid` are high at cycle 4, for exactly one clock.
- **Output rate.** `pcm_valid` occurs exactly once per 2^DECIM_LOG2 `ce` pulses. With `ce` held high, the period is 64 clocks for D=6.
- **No overlap.** The capture interval is at least 32 clocks and the pipeline is 4 clocks deep, so successive samples never overlap.
- **Output hold.** `pcm_x` holds its value between `pcm_valid` pulses.
- **`ce` low.** Integrators, counter and `fb_x` freeze. A comb pipeline already in flight still completes.

## Test plan
- **Full-scale positive.** Defaults, `ce`=1, `bs_left`=1 constant for 8 output periods -> after settling, `pcm_left`=0x7FFF (saturated from +32768). `pcm_valid` period is 64 clocks.
- **Full-scale negative.** `bs_right`=0 constant -> `pcm_right`=0x8000 (-32768) after settling. Left and right are independent when driven with different patterns.
- **Midscale and 75% duty.** `bs_left` alternating 1,0 at `ce` rate -> `pcm_left`=0x0000. Pattern 1,1,1,0 -> `pcm_left`=0x4000 (+16384) after settling.
- **`ce` gating.** `ce` asserted every other clock with the 1,1,1,0 pattern -> same 0x4000 output. `pcm_valid` period is 128 clocks. `fb_x` changes only on `ce` cycles.
- **Reset behaviour.** Assert `reset` for 1 clock mid-way through an output period with all-ones input -> next clock all outputs are 0 and `pcm_valid`=0. The first `pcm_valid` comes 64 `ce` pulses + 4 clocks later, and the output reaches 0x7FFF by the 4th post-reset sample.
- **Feedback latency.** Toggle `bs_left` once with `ce`=1 -> `fb_left` follows exactly 3 clocks later.
